reaction_timer_ctrl: RTL and testbench

//  Sequencer for the 4-digit BCD reaction counter. On Start it waits a pseudo-random

---
 rtl/reaction_pkg.sv | 24 ++
 rtl/ms_tick_gen.sv | 36 +++
 rtl/reaction_timer_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer sequencer.
// State encoding, LFSR taps and the default full-scale count.
package reaction_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ARM   = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DONE  = 3'd3;
  localparam state_t ST_FAULT = 3'd4;

  // Fibonacci taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int MAX_MS_DEFAULT = 9999;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running tick divider: one-Clock pulse every CLK_HZ/TICK_HZ Clocks.
// A restart clears the count so the next tick is one full period away.
module ms_tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer sequencer: random pre-delay, stimulus LED, 1 ms count enable.
// Optional false-start detection when REACTION_FALSE_START_EN is defined.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          TICK_HZ      = 1000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 10,
  parameter int          MAX_MS       = MAX_MS_DEFAULT,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic Start,
  input  logic Stop,
  output logic BCD_Clear,
  output logic BCD_Enable,
  output logic LED,
  output logic Busy,
  output logic Timeout,
  output logic False_start
);

  localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
  localparam int MW = $clog2(MAX_MS + 1);

  state_t        state_q, state_d;
  logic          start_q, stop_q;
  logic          start_ev, stop_ev;
  logic [15:0]   lfsr_q;
  logic [DW-1:0] delay_q, delay_d;
  logic [DW-1:0] delay_load;
  logic [MW-1:0] ms_q, ms_d;
  logic          timeout_q, timeout_d;
  logic          tick;
  logic          restart;

  assign start_ev = Start & ~start_q;
  assign stop_ev  = Stop & ~stop_q;

  assign delay_load = DW'(MIN_DELAY_MS)
                    + DW'(lfsr_q[RAND_BITS-1:0]);

  // Divider realigns whenever ARM or RUN is entered
  assign restart = (state_d == ST_ARM && state_q != ST_ARM)
                || (state_d == ST_RUN && state_q != ST_RUN);

  ms_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      start_q <= Start;
      stop_q  <= Stop;
      lfsr_q  <= lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      delay_q   <= '0;
      ms_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      delay_q   <= delay_d;
      ms_q      <= ms_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    ms_d      = ms_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d = ST_ARM;
          delay_d = delay_load;
        end
      end
      ST_ARM: begin
`ifdef REACTION_FALSE_START_EN
        if (stop_ev) begin
          state_d = ST_FAULT;
        end else
`endif
        if (delay_q == '0
            || (tick && delay_q == DW'(1))) begin
          state_d = ST_RUN;
          delay_d = '0;
          ms_d    = '0;
        end else if (tick) begin
          delay_d = delay_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) begin
          ms_d = ms_q + 1'b1;
        end
        // Full scale reached on this tick beats a coincident Stop
        if (tick && ms_q == MW'(MAX_MS - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else if (stop_ev) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_ev) begin
          state_d   = ST_ARM;
          delay_d   = delay_load;
          timeout_d = 1'b0;
        end
      end
`ifdef REACTION_FALSE_START_EN
      ST_FAULT: begin
        if (start_ev) begin
          state_d = ST_ARM;
          delay_d = delay_load;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    BCD_Clear  = 1'b0;
    BCD_Enable = 1'b0;
    LED        = 1'b0;
    Busy       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        BCD_Clear = 1'b1;
      end
      ST_ARM: begin
        BCD_Clear = 1'b1;
        Busy      = 1'b1;
      end
      ST_RUN: begin
        LED        = 1'b1;
        Busy       = 1'b1;
        BCD_Enable = tick;
      end
      ST_DONE: begin
        BCD_Clear = 1'b0;
      end
`ifdef REACTION_FALSE_START_EN
      ST_FAULT: begin
        BCD_Clear = 1'b1;
      end
`endif
      default: begin
        BCD_Clear = 1'b1;
      end
    endcase
  end

  assign Timeout = timeout_q;

`ifdef REACTION_FALSE_START_EN
  assign False_start = (state_q == ST_FAULT);
`else
  assign False_start = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a 10-Clock tick.
// Tracks the LFSR and a BCD counter model to time Start and check results.
module tb_reaction_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start, stop;
  logic bcd_clear, bcd_enable, led, busy;
  logic timeout, false_start;

  int checks = 0;
  int errors = 0;
  int disp;
  int total_en;
  logic [15:0] lf;

  always #5 clk = ~clk;

  reaction_timer_ctrl #(
    .CLK_HZ       (100),
    .TICK_HZ      (10),
    .MIN_DELAY_MS (3),
    .RAND_BITS    (2),
    .MAX_MS       (12),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .Clock       (clk),
    .Resetn      (rst_n),
    .Start       (start),
    .Stop        (stop),
    .BCD_Clear   (bcd_clear),
    .BCD_Enable  (bcd_enable),
    .LED         (led),
    .Busy        (busy),
    .Timeout     (timeout),
    .False_start (false_start)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lf <= 16'hACE1;
    else lf <= {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
  end

  always @(posedge clk) begin
    if (bcd_clear) disp <= 0;
    else if (bcd_enable) disp <= disp + 1;
  end

  initial total_en = 0;
  always @(posedge clk) if (bcd_enable) total_en <= total_en + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    cyc(3);
    rst_n = 1'b1;
  endtask

  // Raise Start on the negedge where the DUT LFSR low bits match
  task automatic arm_at(input logic [1:0] bits);
    int n = 0;
    while (lf[1:0] !== bits && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL lfsr_wait: low bits %b never reached want %b",
               lf[1:0], bits);
    end
    start = 1'b1;
  endtask

  // Start with delay 5 ticks; returns on the negedge after LED rises
  task automatic run_to_led(input string tag);
    arm_at(2'd2);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, bcd_clear, led} !== 3'b110) begin
      errors++;
      $display("FAIL %s_arm: busy/clr/led=%b want 110",
               tag, {busy, bcd_clear, led});
    end
    cyc(49);
    checks++;
    if (led !== 1'b0) begin
      errors++;
      $display("FAIL %s_led_early: led=%b want 0", tag, led);
    end
    cyc(1);
    checks++;
    if ({led, bcd_clear} !== 2'b10) begin
      errors++;
      $display("FAIL %s_led_rise: led/clr=%b want 10",
               tag, {led, bcd_clear});
    end
  endtask

  task automatic test_reset();
    int base;
    do_reset();
    checks++;
    if ({bcd_clear, led, busy, timeout, false_start} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_out: got %b want 10000",
               {bcd_clear, led, busy, timeout, false_start});
    end
    base = total_en;
    cyc(50);
    checks++;
    if ({bcd_clear, led, busy} !== 3'b100 || total_en != base) begin
      errors++;
      $display("FAIL idle_50: clr/led/busy=%b en=%0d want 100 en=0",
               {bcd_clear, led, busy}, total_en - base);
    end
  endtask

  task automatic test_stop();
    run_to_led("stop");
    cyc(70);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if ({led, busy, bcd_clear} !== 3'b000) begin
      errors++;
      $display("FAIL stop_done: led/busy/clr=%b want 000",
               {led, busy, bcd_clear});
    end
    cyc(30);
    checks++;
    if (disp != 7) begin
      errors++;
      $display("FAIL stop_count: got %0d want 7", disp);
    end
  endtask

  task automatic test_timeout();
    run_to_led("to");
    cyc(119);
    checks++;
    if ({led, timeout} !== 2'b10) begin
      errors++;
      $display("FAIL to_before: led/to=%b want 10", {led, timeout});
    end
    cyc(1);
    checks++;
    if ({led, timeout, busy} !== 3'b010 || disp != 12) begin
      errors++;
      $display("FAIL to_hit: led/to/busy=%b cnt=%0d want 010 cnt=12",
               {led, timeout, busy}, disp);
    end
    cyc(20);
    checks++;
    if (timeout !== 1'b1 || disp != 12) begin
      errors++;
      $display("FAIL to_sticky: to=%b cnt=%0d want 1 cnt=12",
               timeout, disp);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({timeout, busy, bcd_clear} !== 3'b011) begin
      errors++;
      $display("FAIL to_clear: to/busy/clr=%b want 011",
               {timeout, busy, bcd_clear});
    end
  endtask

  task automatic test_stop_in_arm();
    do_reset();
    arm_at(2'd2);
    @(negedge clk);
    start = 1'b0;
    cyc(19);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
`ifdef REACTION_FALSE_START_EN
    checks++;
    if ({false_start, led, bcd_clear, busy} !== 4'b1010) begin
      errors++;
      $display("FAIL fs_set: fs/led/clr/busy=%b want 1010",
               {false_start, led, bcd_clear, busy});
    end
    cyc(40);
    checks++;
    if ({false_start, led} !== 2'b10) begin
      errors++;
      $display("FAIL fs_hold: fs/led=%b want 10", {false_start, led});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({false_start, busy} !== 2'b01) begin
      errors++;
      $display("FAIL fs_clear: fs/busy=%b want 01", {false_start, busy});
    end
`else
    cyc(29);
    checks++;
    if ({led, busy, false_start} !== 3'b010) begin
      errors++;
      $display("FAIL arm_stop_early: led/busy/fs=%b want 010",
               {led, busy, false_start});
    end
    cyc(1);
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL arm_stop_led: led=%b want 1", led);
    end
`endif
  endtask

  task automatic test_start_stop_same();
    do_reset();
    run_to_led("both");
    cyc(5);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if ({led, busy} !== 2'b00) begin
      errors++;
      $display("FAIL both_done: led/busy=%b want 00", {led, busy});
    end
    cyc(40);
    checks++;
    if ({led, busy, bcd_clear} !== 3'b000) begin
      errors++;
      $display("FAIL both_held: led/busy/clr=%b want 000",
               {led, busy, bcd_clear});
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    int base;
    do_reset();
    run_to_led("ar");
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({led, bcd_clear, busy} !== 3'b010) begin
      errors++;
      $display("FAIL async_rst: led/clr/busy=%b want 010",
               {led, bcd_clear, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = total_en;
    cyc(20);
    checks++;
    if ({led, bcd_clear, busy} !== 3'b010 || total_en != base) begin
      errors++;
      $display("FAIL after_rst: led/clr/busy=%b en=%0d want 010 en=0",
               {led, bcd_clear, busy}, total_en - base);
    end
  endtask

  initial begin
    test_reset();
    test_stop();
    test_timeout();
    test_stop_in_arm();
    test_start_stop_same();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
